// File: rtl/ad5543_stream_dac.sv
// ad5543_stream_dac: AXI-Stream sample FIFO feeding an AD5543 3-wire serial DAC.
// Samples are released one per SAMPLE_DIV aclk cycles and shifted out MSB-first.
// fifo_irq tells software to re-arm the DMA before the buffer drains.
// Build option: define AD5543_OFFSET_BINARY_EN to invert each sample's MSB before
// it is shifted out (two's complement to offset binary, for bipolar wiring).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cs_n high, waiting for a sample tick
// ST_SETUP | cs_n low, sclk low, sdi holds the MSB
// ST_HIGH  | sclk high, sdi stable (the DAC samples on the rising edge)
// ST_LOW   | sclk low, sdi moves to the next bit (bit 0 held on the last pass)
// ST_LATCH | cs_n high, sclk low; the cs_n rising edge latches the DAC
module ad5543_stream_dac #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int SCLK_DIV   = 4,
  parameter int SAMPLE_DIV = 1000,
  parameter int LOW_THRESH = 64
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               en,
  input  logic [DW-1:0]                      s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic                               sclk,
  output logic                               sdi,
  output logic                               cs_n,
  output logic                               fifo_irq,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_LOW   = LW'(LOW_THRESH);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_t;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic [TW-1:0] tick_cnt;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] load_word;
  logic [DW-1:0] shreg;
  logic [PW-1:0] ph_cnt;
  logic [BW-1:0] bit_cnt;
  state_t        state;
  logic          tick;
  logic          empty;
  logic          push;
  logic          pop;

  assign tick    = en && (tick_cnt == TICK_LAST);
  assign empty   = (fifo_level == '0);
  // tready is the registered not-full flag, so a full FIFO refuses a beat even
  // when a pop happens in the same cycle.
  assign push    = s_axis_tvalid && s_axis_tready;
  assign pop     = tick && (state == ST_IDLE) && !empty;
  assign rd_data = mem[rd_ptr];

`ifdef AD5543_OFFSET_BINARY_EN
  assign load_word = {~rd_data[DW-1], rd_data[DW-2:0]};
`else
  assign load_word = rd_data;
`endif

  // Next occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LW'(1);
    end else if (pop && !push) begin
      level_next = fifo_level - LW'(1);
    end
  end

  // Sample storage, written on every accepted beat.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_level    <= level_next;
      s_axis_tready <= (level_next != LVL_FULL);
    end
  end

  // Sample-rate counter; parked at zero while disabled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tick_cnt <= '0;
    end else if (!en || (tick_cnt == TICK_LAST)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Low-water interrupt and sticky underrun flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_irq <= 1'b0;
      underrun <= 1'b0;
    end else begin
      fifo_irq <= (fifo_level <= LVL_LOW) && en;
      if (tick && (state == ST_IDLE) && empty) begin
        underrun <= 1'b1;
      end
    end
  end

  // Serializer FSM with registered sclk/sdi/cs_n.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      sdi     <= 1'b0;
      cs_n    <= 1'b1;
    end else if ((state != ST_IDLE) && (ph_cnt != '0)) begin
      ph_cnt <= ph_cnt - PW'(1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_SETUP;
            ph_cnt  <= PH_LAST;
            bit_cnt <= '0;
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            sdi     <= load_word[DW-1];
            shreg   <= load_word << 1;
          end
        end
        ST_SETUP: begin
          state  <= ST_HIGH;
          ph_cnt <= PH_LAST;
          sclk   <= 1'b1;
        end
        ST_HIGH: begin
          state  <= ST_LOW;
          ph_cnt <= PH_LAST;
          sclk   <= 1'b0;
          if (bit_cnt != BIT_LAST) begin
            sdi   <= shreg[DW-1];
            shreg <= shreg << 1;
          end
        end
        ST_LOW: begin
          ph_cnt <= PH_LAST;
          if (bit_cnt == BIT_LAST) begin
            state <= ST_LATCH;
            cs_n  <= 1'b1;
          end else begin
            state   <= ST_HIGH;
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_LATCH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad5543_stream_dac.sv
// Testbench for ad5543_stream_dac: scoreboard of pushed samples, a serial-bus
// monitor that rebuilds each frame from the sclk rising edges, and directed steps.
module tb_ad5543_stream_dac;

  localparam int DW         = 16;
  localparam int FIFO_DEPTH = 256;
  localparam int SCLK_DIV   = 4;
  localparam int SAMPLE_DIV = 140;
  localparam int LOW_THRESH = 64;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          sclk;
  logic          sdi;
  logic          cs_n;
  logic          fifo_irq;
  logic [LW-1:0] fifo_level;
  logic          underrun;

  int            vectors = 0;
  int            miscompares = 0;
  logic [15:0]   sb [$];

  // monitor state
  int            cyc = 0;
  logic          sclk_q = 1'b0;
  logic          sdi_q = 1'b0;
  logic          cs_q = 1'b1;
  logic          irq_q = 1'b0;
  int            lvl_q = 0;
  int            start_cyc = 0;
  int            rise_cyc = 0;
  int            last_start = 0;
  logic          start_valid = 1'b0;
  logic          in_frame = 1'b0;
  int            bits = 0;
  logic [15:0]   word = '0;
  logic [15:0]   last_word = '0;
  int            frames_done = 0;
  int            frames_started = 0;
  logic          gap_chk = 1'b0;
  logic          irq_chk = 1'b0;
  logic          irq_fell = 1'b0;
  logic          irq_rose = 1'b0;

  always #5 aclk = ~aclk;

  ad5543_stream_dac #(
    .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .SCLK_DIV(SCLK_DIV),
    .SAMPLE_DIV(SAMPLE_DIV), .LOW_THRESH(LOW_THRESH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .en(en),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .sclk(sclk), .sdi(sdi), .cs_n(cs_n), .fifo_irq(fifo_irq),
    .fifo_level(fifo_level), .underrun(underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] xf(input logic [15:0] d);
`ifdef AD5543_OFFSET_BINARY_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  function automatic logic [15:0] sine_val(input int i);
    real r;
    r = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 200.0);
    return 16'($rtoi(r));
  endfunction

  // Rebuild frames from the bus and check timing, bit stability and data.
  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      in_frame    = 1'b0;
      start_valid = 1'b0;
      bits        = 0;
      irq_fell    = 1'b0;
      irq_rose    = 1'b0;
    end else begin
      if (cs_q && !cs_n) begin
        if (gap_chk && start_valid) check("frame_gap", 32'(cyc - last_start), 32'(SAMPLE_DIV));
        last_start  = cyc;
        start_valid = 1'b1;
        start_cyc   = cyc;
        bits        = 0;
        word        = '0;
        in_frame    = 1'b1;
        frames_started++;
      end
      if (in_frame && !cs_n) begin
        if (!sclk_q && sclk) begin
          check("sdi_at_rise", 32'(sdi), 32'(sdi_q));
          if (bits == 0) check("first_rise", 32'(cyc - start_cyc), 32'(SCLK_DIV));
          else check("rise_spacing", 32'(cyc - rise_cyc), 32'(2 * SCLK_DIV));
          rise_cyc = cyc;
          word     = {word[14:0], sdi};
          bits++;
        end else if (sclk_q && sclk) begin
          check("sdi_hold_high", 32'(sdi), 32'(sdi_q));
        end
      end
      if (in_frame && !cs_q && cs_n) begin
        check("cs_low_len", 32'(cyc - start_cyc), 32'((2 * DW + 1) * SCLK_DIV));
        check("bit_count", 32'(bits), 32'(DW));
        check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) check("frame_data", 32'(word), 32'(sb.pop_front()));
        last_word = word;
        frames_done++;
        in_frame = 1'b0;
      end
      if (irq_chk) begin
        check("irq_level", 32'(fifo_irq), 32'(lvl_q <= LOW_THRESH));
        if (irq_q && !fifo_irq) begin
          irq_fell = 1'b1;
          check("irq_fall_level", 32'(lvl_q), 32'(LOW_THRESH + 1));
        end
        if (!irq_q && fifo_irq) begin
          irq_rose = 1'b1;
          check("irq_rise_level", 32'(lvl_q), 32'(LOW_THRESH));
        end
      end
    end
    sclk_q = sclk;
    sdi_q  = sdi;
    cs_q   = cs_n;
    irq_q  = fifo_irq;
    lvl_q  = int'(fifo_level);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge aclk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    sb.delete();
    step(n);
    aresetn = 1'b1;
    step(1);
  endtask

  task automatic push(input logic [15:0] d, input int budget);
    logic ok;
    ok     = 1'b0;
    tdata  = d;
    tvalid = 1'b1;
    for (int k = 0; k < budget && !ok; k++) begin
      if (tready) begin
        sb.push_back(xf(d));
        ok = 1'b1;
      end
      step(1);
    end
    tvalid = 1'b0;
    check("push_accept", 32'(ok), 32'(1));
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (frames_done < target && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(frames_done >= target), 32'(1));
  endtask

  initial begin
    int base;
    logic ok;
    logic [15:0] exp_word;

    // reset with tvalid held high
    aresetn = 1'b0;
    tvalid  = 1'b1;
    tdata   = 16'hFFFF;
    step(20);
    check("rst_cs_n", 32'(cs_n), 32'(1));
    check("rst_sclk", 32'(sclk), 32'(0));
    check("rst_sdi", 32'(sdi), 32'(0));
    check("rst_tready", 32'(tready), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_irq", 32'(fifo_irq), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    aresetn = 1'b1;
    step(1);
    check("tready_after_rst", 32'(tready), 32'(1));
    tvalid = 1'b0;
    step(2);
    check("level_no_push", 32'(fifo_level), 32'(0));

    // single frame
    push(16'h5A3C, 4);
    check("level_one", 32'(fifo_level), 32'(1));
    en = 1'b1;
    wait_frames(frames_done + 1, 2 * SAMPLE_DIV + 200, "single_done");
`ifdef AD5543_OFFSET_BINARY_EN
    exp_word = 16'hDA3C;
`else
    exp_word = 16'h5A3C;
`endif
    check("single_word", 32'(last_word), 32'(exp_word));
    check("single_level", 32'(fifo_level), 32'(0));
    check("single_no_underrun", 32'(underrun), 32'(0));
    check("irq_empty_en", 32'(fifo_irq), 32'(1));
    en = 1'b0;
    step(2);
    check("irq_disabled", 32'(fifo_irq), 32'(0));

    // sine stream with irq hysteresis-free threshold tracking
    do_reset(3);
    en = 1'b1;
    step(2);
    irq_chk = 1'b1;
    gap_chk = 1'b1;
    base = frames_done;
    for (int i = 0; i < 200; i++) push(sine_val(i), 4);
    wait_frames(base + 200, 200 * SAMPLE_DIV + 1000, "sine_done");
    irq_chk = 1'b0;
    gap_chk = 1'b0;
    check("sine_sb_drained", 32'(sb.size()), 32'(0));
    check("sine_irq_fell", 32'(irq_fell), 32'(1));
    check("sine_irq_rose", 32'(irq_rose), 32'(1));
    en = 1'b0;

    // full FIFO
    do_reset(3);
    for (int i = 0; i < FIFO_DEPTH; i++) push(16'(i * 97 + 3), 4);
    check("full_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("full_tready", 32'(tready), 32'(0));
    tdata  = 16'hBEEF;
    tvalid = 1'b1;
    step(10);
    check("stall_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("stall_tready", 32'(tready), 32'(0));
    base = frames_done;
    en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2 * SAMPLE_DIV && !ok; k++) begin
      if (tready) ok = 1'b1;
      else step(1);
    end
    check("tready_after_pop", 32'(ok), 32'(1));
    if (ok) sb.push_back(xf(16'hBEEF));
    step(1);
    tvalid = 1'b0;
    check("refill_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("refill_tready", 32'(tready), 32'(0));
    wait_frames(base + 1, 2 * SAMPLE_DIV + 200, "full_first_frame");
    en = 1'b0;

    // underrun
    do_reset(3);
    base = frames_started;
    en = 1'b1;
    step(SAMPLE_DIV - 10);
    check("underrun_before_tick", 32'(underrun), 32'(0));
    step(20);
    check("underrun_set", 32'(underrun), 32'(1));
    check("underrun_no_frame", 32'(frames_started - base), 32'(0));
    check("underrun_cs_n", 32'(cs_n), 32'(1));
    base = frames_done;
    push(16'h8001, 4);
    wait_frames(base + 1, 2 * SAMPLE_DIV + 200, "underrun_frame");
`ifdef AD5543_OFFSET_BINARY_EN
    exp_word = 16'h0001;
`else
    exp_word = 16'h8001;
`endif
    check("underrun_word", 32'(last_word), 32'(exp_word));
    check("underrun_sticky", 32'(underrun), 32'(1));
    en = 1'b0;

    // abort mid-frame during HIGH(7)
    do_reset(3);
    push(16'h1357, 4);
    base = frames_done;
    en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2 * SAMPLE_DIV + 200 && !ok; k++) begin
      if (bits == 8 && sclk && !cs_n) ok = 1'b1;
      else step(1);
    end
    check("abort_reach_high7", 32'(ok), 32'(1));
    #2;
    aresetn = 1'b0;
    sb.delete();
    #1;
    check("abort_cs_n", 32'(cs_n), 32'(1));
    check("abort_sclk", 32'(sclk), 32'(0));
    check("abort_level", 32'(fifo_level), 32'(0));
    step(3);
    aresetn = 1'b1;
    step(SAMPLE_DIV + 20);
    check("abort_no_latch", 32'(frames_done - base), 32'(0));
    check("abort_cs_idle", 32'(cs_n), 32'(1));
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
